intersection_controller: RTL and testbench
==========================================

Name: intersection_controller

Overview:
- Sequences a two-road intersection: main road north-south (NS) and side road east-west (EW), plus a pedestrian walk phase.
- Drives one red/green/yellow lamp set per road and a walk lamp, all one-hot per road.
- NS rests in green. EW and pedestrian requests are latched and served in turn, with an all-red clearance interval between conflicting greens.
- Sits above the per-road lamp datapath and arbitrates green time between the two roads and pedestrians.

Parameters:
- GREEN_CYC, 20: green duration in cycles; minimum for NS, fixed for EW.
- YELLOW_CYC, 3: yellow duration in cycles.
- CLEAR_CYC, 2: all-red clearance duration in cycles.
- WALK_CYC, 10: walk phase duration in cycles.
- CNT_W, 6: phase timer width; must hold max(all durations)-1.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- ew_req  input  1  EW vehicle detector; any high cycle is latched
- ped_req  input  1  pedestrian button; any high cycle is latched
- ns_green_on / ns_yellow_on / ns_red_on  output  1 each  NS lamps
- ew_green_on / ew_yellow_on / ew_red_on  output  1 each  EW lamps
- walk_on  output  1  pedestrian walk lamp
- ped_wait  output  1  pedestrian request pending
- phase  output  3  current state encoding, for debug and verification

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, reset_n.
- States and phase encodings: NS_G=0, NS_Y=1, CLR_A=2, EW_G=3, EW_Y=4, CLR_B=5, WALK=6. Encodings 7 and any illegal value go to NS_G on the next clock.
- Reset values:
  - state NS_G, timer 0, ew_pend=0, ped_pend=0.
  - Outputs: ns_green_on=1, ew_red_on=1, all other lamps 0, ped_wait=0, phase=0.
- Timer:
  - Cleared to 0 on the cycle a state is entered; increments by 1 each cycle.
  - A timed state with duration D is left when timer==D-1, so it occupies exactly D cycles.
  - In NS_G the timer saturates at GREEN_CYC-1 and never wraps.
- Transitions:
  - NS_G -> NS_Y when timer==GREEN_CYC-1 and (ew_pend or ped_pend); otherwise hold.
  - NS_Y -> CLR_A after YELLOW_CYC.
  - CLR_A -> EW_G after CLEAR_CYC.
  - EW_G -> EW_Y after GREEN_CYC; EW_G is served even if only ped_pend is set.
  - EW_Y -> CLR_B after YELLOW_CYC.
  - CLR_B -> WALK after CLEAR_CYC if ped_pend, else -> NS_G.
  - WALK -> NS_G after WALK_CYC.
- Request latches:
  - ew_pend is set by ew_req and cleared on the cycle EW_G is entered. ew_req high on that entry cycle or during EW_G is ignored.
  - ped_pend is set by ped_req and cleared on the cycle WALK is entered. ped_req high on that entry cycle or during WALK is ignored.
  - A request arriving in any other state is retained until it is served.
- Outputs are Moore, decoded combinationally from state only:
  - NS lamps: green in NS_G, yellow in NS_Y, red in all other states.
  - EW lamps: green in EW_G, yellow in EW_Y, red in all other states.
  - walk_on is high only in WALK, with both roads red.
  - ped_wait = ped_pend.
- Safety invariants, checked every cycle:
  - Exactly one lamp is on per road.
  - ns_green_on and ew_green_on are never both high.
  - walk_on is never high together with any green or yellow lamp.
- Reset mid-phase returns immediately to the reset values; pending requests are discarded.

Optional Feature:
- Macro: EMERG_PREEMPT_EN.
- With the macro defined:
  - An extra input port emerg (1 bit) is added.
  - While emerg is high: NS_G ignores ew_pend and ped_pend and holds.
  - emerg high in EW_G forces EW_Y on the next cycle with the timer cleared.
  - emerg high in WALK forces CLR_B on the next cycle; ped_pend stays cleared.
  - All other states are unaffected; request latches still capture requests.
- Without the macro: no emerg port, and behaviour is exactly the base behaviour.

Test Plan:
- Reset released at cycle 0 with no requests for 100 cycles -> NS_G throughout, phase=0, ns_green_on=1, ew_red_on=1, timer held at 19.
- ew_req one-cycle pulse at cycle 5 -> NS_G 0-19, NS_Y 20-22, CLR_A 23-24, EW_G 25-44, EW_Y 45-47, CLR_B 48-49, NS_G from 50.
- ped_req pulse at cycle 5 with no ew_req -> same sequence through CLR_B 48-49, then WALK 50-59 with walk_on=1, then NS_G at 60. ped_wait is high from cycle 6 to 50.
- ew_req pulse at cycle 30 while in NS_G -> NS_Y entered at cycle 31. A second ew_req pulse during EW_G -> no second EW cycle.
- reset_n low at cycle 47 (EW_Y) with ped_pend set -> outputs return to reset values asynchronously; ped_wait=0; NS_G held afterwards.
- EMERG_PREEMPT_EN build: emerg high at cycle 30 while in EW_G -> EW_Y 31-33, CLR_B 34-35, NS_G at 36.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-road intersection sequencer: NS main road resting green, EW side road and pedestrian walk on request.
// Optional EMERG_PREEMPT_EN adds an emerg input that holds NS green and cuts EW green / walk short.
module intersection_controller #(
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 3,
  parameter int CLEAR_CYC  = 2,
  parameter int WALK_CYC   = 10,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ew_req,
  input  logic       ped_req,
`ifdef EMERG_PREEMPT_EN
  input  logic       emerg,
`endif
  output logic       ns_green_on,
  output logic       ns_yellow_on,
  output logic       ns_red_on,
  output logic       ew_green_on,
  output logic       ew_yellow_on,
  output logic       ew_red_on,
  output logic       walk_on,
  output logic       ped_wait,
  output logic [2:0] phase
);

  // state | meaning
  // NS_G  | NS green, rests here until a request is pending
  // NS_Y  | NS yellow
  // CLR_A | all red before EW green
  // EW_G  | EW green, fixed length
  // EW_Y  | EW yellow
  // CLR_B | all red, then walk if a pedestrian waits
  // WALK  | pedestrian walk, both roads red
  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    CLR_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    CLR_B = 3'd5,
    WALK  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WALK_CYC - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic             ew_pend;
  logic             ped_pend;
  logic             ew_any;
  logic             ped_any;
  logic             emerg_act;

`ifdef EMERG_PREEMPT_EN
  assign emerg_act = emerg;
`else
  assign emerg_act = 1'b0;
`endif

  // A request present this very cycle counts as pending for the decision
  assign ew_any  = ew_pend | ew_req;
  assign ped_any = ped_pend | ped_req;

  always_comb begin
    nxt = state;
    case (state)
      NS_G:  if (timer == G_LAST && (ew_any || ped_any) && !emerg_act) nxt = NS_Y;
      NS_Y:  if (timer == Y_LAST) nxt = CLR_A;
      CLR_A: if (timer == C_LAST) nxt = EW_G;
      EW_G:  if (emerg_act || timer == G_LAST) nxt = EW_Y;
      EW_Y:  if (timer == Y_LAST) nxt = CLR_B;
      CLR_B: if (timer == C_LAST) nxt = ped_any ? WALK : NS_G;
      WALK: begin
        if (emerg_act)            nxt = CLR_B;
        else if (timer == W_LAST) nxt = NS_G;
      end
      default: nxt = NS_G;
    endcase
  end

  always_comb begin
    timer_nxt = timer + CNT_W'(1);
    if (nxt != state)
      timer_nxt = '0;
    else if (state == NS_G && timer == G_LAST)
      timer_nxt = timer;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= NS_G;
      timer        <= '0;
      ew_pend      <= 1'b0;
      ped_pend     <= 1'b0;
      ns_green_on  <= 1'b1;
      ns_yellow_on <= 1'b0;
      ns_red_on    <= 1'b0;
      ew_green_on  <= 1'b0;
      ew_yellow_on <= 1'b0;
      ew_red_on    <= 1'b1;
      walk_on      <= 1'b0;
    end else begin
      state        <= nxt;
      timer        <= timer_nxt;
      // Clearing wins over a new request for the whole served phase
      ew_pend      <= (state == EW_G) ? 1'b0 : ew_any;
      ped_pend     <= (state == WALK) ? 1'b0 : ped_any;
      ns_green_on  <= (nxt == NS_G);
      ns_yellow_on <= (nxt == NS_Y);
      ns_red_on    <= !(nxt == NS_G || nxt == NS_Y);
      ew_green_on  <= (nxt == EW_G);
      ew_yellow_on <= (nxt == EW_Y);
      ew_red_on    <= !(nxt == EW_G || nxt == EW_Y);
      walk_on      <= (nxt == WALK);
    end
  end

  assign ped_wait = ped_pend;
  assign phase    = state;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: directed test-plan scenarios plus random
// requests, compared every cycle against a phase/duration reference model.
module tb_intersection_controller;

  localparam int GREEN_CYC  = 20;
  localparam int YELLOW_CYC = 3;
  localparam int CLEAR_CYC  = 2;
  localparam int WALK_CYC   = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ew_req = 1'b0;
  logic       ped_req = 1'b0;
`ifdef EMERG_PREEMPT_EN
  logic       emerg = 1'b0;
`endif
  logic       ns_green_on, ns_yellow_on, ns_red_on;
  logic       ew_green_on, ew_yellow_on, ew_red_on;
  logic       walk_on, ped_wait;
  logic [2:0] phase;
  logic [7:0] dut_lamps;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;

  // reference model: phase number, cycles already spent in it, pending flags
  int m_phase;
  int m_elapsed;
  bit m_ew;
  bit m_ped;

  typedef struct {int cyc; int kind; int val;} plan_t;  // kind 0: phase, 1: ped_wait
  plan_t plan[$];

  always #5 clk = ~clk;

  intersection_controller #(
    .GREEN_CYC(GREEN_CYC), .YELLOW_CYC(YELLOW_CYC), .CLEAR_CYC(CLEAR_CYC),
    .WALK_CYC(WALK_CYC), .CNT_W(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ew_req(ew_req), .ped_req(ped_req),
`ifdef EMERG_PREEMPT_EN
    .emerg(emerg),
`endif
    .ns_green_on(ns_green_on), .ns_yellow_on(ns_yellow_on), .ns_red_on(ns_red_on),
    .ew_green_on(ew_green_on), .ew_yellow_on(ew_yellow_on), .ew_red_on(ew_red_on),
    .walk_on(walk_on), .ped_wait(ped_wait), .phase(phase)
  );

  assign dut_lamps = {ns_green_on, ns_yellow_on, ns_red_on,
                      ew_green_on, ew_yellow_on, ew_red_on, walk_on, ped_wait};

  function automatic int dur(input int p);
    case (p)
      0, 3:    return GREEN_CYC;
      1, 4:    return YELLOW_CYC;
      2, 5:    return CLEAR_CYC;
      default: return WALK_CYC;
    endcase
  endfunction

  function automatic logic [7:0] exp_lamps();
    bit ng, ny, eg, ey;
    ng = (m_phase == 0);
    ny = (m_phase == 1);
    eg = (m_phase == 3);
    ey = (m_phase == 4);
    return {ng, ny, !(ng || ny), eg, ey, !(eg || ey), m_phase == 6, m_ped};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_elapsed = 0;
    m_ew = 0;
    m_ped = 0;
  endtask

  task automatic model_step(input bit ew, input bit ped, input bit em_in);
    bit ew_any, ped_any, done, em;
    int np;
`ifdef EMERG_PREEMPT_EN
    em = em_in;
`else
    em = 1'b0 & em_in;
`endif
    ew_any  = m_ew | ew;
    ped_any = m_ped | ped;
    done    = (m_elapsed + 1 >= dur(m_phase));
    np      = m_phase;
    case (m_phase)
      0: if (done && (ew_any || ped_any) && !em) np = 1;
      3: if (em || done) np = 4;
      5: if (done) np = ped_any ? 6 : 0;
      6: if (em) np = 5; else if (done) np = 0;
      default: if (done) np = m_phase + 1;
    endcase
    m_ew  = (m_phase == 3) ? 1'b0 : ew_any;
    m_ped = (m_phase == 6) ? 1'b0 : ped_any;
    m_elapsed = (np != m_phase) ? 0 : m_elapsed + 1;
    m_phase = np;
  endtask

  task automatic cyc(input bit ew, input bit ped, input bit em);
    chk("phase", 8'(phase), 8'(m_phase));
    chk("lamps", dut_lamps, exp_lamps());
    chk("ns_onehot", 8'($countones(dut_lamps[7:5])), 8'd1);
    chk("ew_onehot", 8'($countones(dut_lamps[4:2])), 8'd1);
    chk("green_excl", 8'(ns_green_on & ew_green_on), 8'd0);
    chk("walk_excl", 8'(walk_on & (ns_green_on | ns_yellow_on | ew_green_on | ew_yellow_on)), 8'd0);
    while (plan.size() > 0 && plan[0].cyc == cycle) begin
      if (plan[0].kind == 0) chk("plan_phase", 8'(phase), 8'(plan[0].val));
      else                   chk("plan_ped_wait", 8'(ped_wait), 8'(plan[0].val));
      void'(plan.pop_front());
    end
    ew_req  = ew;
    ped_req = ped;
`ifdef EMERG_PREEMPT_EN
    emerg = em;
`endif
    model_step(ew, ped, em);
    @(negedge clk);
    cycle++;
  endtask

  task automatic run(input int n, input int ew_at, input int ew2_at, input int ped_at, input int em_at);
    for (int i = 0; i < n; i++)
      cyc(cycle == ew_at || cycle == ew2_at, cycle == ped_at, cycle == em_at);
    chk("plan_unreached", 8'(plan.size()), 8'd0);
    plan.delete();
  endtask

  // Reset lands between clock edges so its asynchronous effect is observable
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    ew_req  = 1'b0;
    ped_req = 1'b0;
`ifdef EMERG_PREEMPT_EN
    emerg = 1'b0;
`endif
    #1;
    chk("rst_lamps", dut_lamps, 8'b1000_0100);
    chk("rst_phase", 8'(phase), 8'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycle = 0;
  endtask

  function automatic void add(input int c, input int k, input int v);
    plan_t e;
    e.cyc = c; e.kind = k; e.val = v;
    plan.push_back(e);
  endfunction

  initial begin
    @(negedge clk);
    do_reset();

    // idle: NS green throughout
    add(0, 0, 0); add(50, 0, 0); add(99, 0, 0);
    run(100, -1, -1, -1, -1);

    // single EW request at cycle 5
    do_reset();
    add(19, 0, 0); add(20, 0, 1); add(22, 0, 1); add(23, 0, 2); add(25, 0, 3);
    add(44, 0, 3); add(45, 0, 4); add(48, 0, 5); add(49, 0, 5); add(50, 0, 0);
    run(60, 5, -1, -1, -1);

    // pedestrian request at cycle 5
    do_reset();
    add(5, 1, 0); add(6, 1, 1); add(25, 0, 3); add(48, 0, 5); add(50, 0, 6);
    add(50, 1, 1); add(51, 1, 0); add(59, 0, 6); add(60, 0, 0);
    run(70, -1, -1, 5, -1);

    // late EW request with saturated timer, second request during EW green ignored
    do_reset();
    add(30, 0, 0); add(31, 0, 1); add(36, 0, 3); add(55, 0, 3); add(56, 0, 4);
    add(61, 0, 0); add(100, 0, 0);
    run(110, 30, 40, -1, -1);

    // reset during EW yellow with a pedestrian pending
    do_reset();
    add(46, 0, 4); add(46, 1, 1);
    run(47, -1, -1, 5, -1);
    do_reset();
    add(0, 0, 0); add(29, 0, 0); add(29, 1, 0);
    run(30, -1, -1, -1, -1);

`ifdef EMERG_PREEMPT_EN
    // emergency during EW green
    do_reset();
    add(30, 0, 3); add(31, 0, 4); add(33, 0, 4); add(34, 0, 5); add(35, 0, 5); add(36, 0, 0);
    run(45, 5, -1, -1, 30);
`endif

    // random request traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit r_ew, r_ped, r_em;
      r_ew  = ($urandom_range(0, 24) == 0);
      r_ped = ($urandom_range(0, 39) == 0);
`ifdef EMERG_PREEMPT_EN
      r_em  = ($urandom_range(0, 29) == 0);
`else
      r_em  = 1'b0;
`endif
      cyc(r_ew, r_ped, r_em);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
